// File: rtl/spi_rw_pkg.sv
// Shared types and constants for the SPI read/write register-bus slave.
package spi_rw_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StData,
      StIgnore
   } state_t;

   localparam logic [7:0] CMD_WRITE_DEFAULT = 8'hFF;
   localparam logic [7:0] CMD_READ_DEFAULT  = 8'h0F;

   function automatic int unsigned max_width(input int unsigned addr_w, input int unsigned data_w);
      int unsigned m;
      m = 8;
      if (addr_w > m) m = addr_w;
      if (data_w > m) m = data_w;
      return m;
   endfunction

   // The counter only needs to reach the longest field length minus one.
   function automatic int unsigned cnt_width(input int unsigned addr_w, input int unsigned data_w);
      return $clog2(max_width(addr_w, data_w));
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with optional edge detect.
module spi_pin_sync #(
   parameter bit RST_VAL = 1'b0,
   parameter bit EDGE_EN = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
         s3_q <= RST_VAL;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign dout = s2_q;
   assign rise = EDGE_EN && s2_q && !s3_q;
   assign fall = EDGE_EN && !s2_q && s3_q;

endmodule

// File: rtl/spi_rw_slave.sv
// SPI mode-0 slave bridging an oversampled SPI master onto the register-bus
// write and read ports, with auto-incrementing bursts and abort reporting.
module spi_rw_slave
   import spi_rw_pkg::*;
#(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DATA_W    = 32,
   parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEFAULT,
   parameter logic [7:0]  CMD_READ  = CMD_READ_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              abort
);

   localparam int unsigned MAX_W = max_width(ADDR_W, DATA_W);
   localparam int unsigned CNT_W = cnt_width(ADDR_W, DATA_W);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
   logic unused_sck_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_pin_sync #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
      .clk (clk),
      .rst (rst),
      .din (spi_sck),
      .dout(unused_sck_lvl),
      .rise(sck_rise),
      .fall(sck_fall)
   );

   // Reset to "selected" so a CS held low across reset never looks like a new falling edge.
   spi_pin_sync #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_cs (
      .clk (clk),
      .rst (rst),
      .din (spi_cs_n),
      .dout(unused_cs_lvl),
      .rise(cs_rise),
      .fall(cs_fall)
   );

   spi_pin_sync #(.RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
      .clk (clk),
      .rst (rst),
      .din (spi_mosi),
      .dout(mosi_s),
      .rise(unused_mosi_rise),
      .fall(unused_mosi_fall)
   );

   state_t             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [MAX_W-1:0]   rx_q;
   logic [MAX_W-1:0]   rx_next;
   logic [DATA_W-1:0]  tx_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               is_read_q, wr_pend_q, rd_pend_q, load_q;

   assign rx_next = {rx_q[MAX_W-2:0], mosi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         is_read_q   <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         load_q      <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         abort       <= 1'b0;
      end else begin
         // Strobes are staged one clk behind the capturing edge.
         wr_en     <= wr_pend_q;
         rd_en     <= rd_pend_q;
         wr_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
         abort     <= 1'b0;
         load_q    <= rd_en;
         if (load_q) tx_q <= rd_data;

         if (cs_rise) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            case (state_q)
               StCmd:  abort <= (bit_cnt_q != '0) || sck_rise;
               StAddr: abort <= 1'b1;
               StData: begin
                  // A last bit landing with the CS release still completes its word.
                  if (sck_rise && bit_cnt_q == DATA_LAST) begin
                     if (!is_read_q) begin
                        wr_pend_q <= 1'b1;
                        wr_addr   <= addr_q;
                        wr_data   <= rx_next[DATA_W-1:0];
                     end
                  end else begin
                     abort <= (bit_cnt_q != '0) || sck_rise;
                  end
               end
               default: ;
            endcase
         end else begin
            case (state_q)
               StIdle: begin
                  if (cs_fall) begin
                     state_q   <= StCmd;
                     bit_cnt_q <= '0;
                  end
               end
               StCmd: begin
                  if (sck_rise) begin
                     rx_q <= rx_next;
                     if (bit_cnt_q == CMD_LAST) begin
                        bit_cnt_q <= '0;
                        if (rx_next[7:0] == CMD_WRITE) begin
                           state_q   <= StAddr;
                           is_read_q <= 1'b0;
                        end else if (rx_next[7:0] == CMD_READ) begin
                           state_q   <= StAddr;
                           is_read_q <= 1'b1;
                        end else begin
                           state_q <= StIgnore;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end
               end
               StAddr: begin
                  if (sck_rise) begin
                     rx_q <= rx_next;
                     if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_q   <= '0;
                        state_q     <= StData;
                        addr_q      <= rx_next[ADDR_W-1:0];
                        spi_miso_oe <= is_read_q;
                        if (is_read_q) begin
                           rd_pend_q <= 1'b1;
                           rd_addr   <= rx_next[ADDR_W-1:0];
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end
               end
               StData: begin
                  if (sck_rise) begin
                     rx_q <= rx_next;
                     if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_q <= '0;
                        addr_q    <= addr_q + 1'b1;
                        if (is_read_q) begin
                           rd_pend_q <= 1'b1;
                           rd_addr   <= addr_q + 1'b1;
                        end else begin
                           wr_pend_q <= 1'b1;
                           wr_addr   <= addr_q;
                           wr_data   <= rx_next[DATA_W-1:0];
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end
                  if (sck_fall && is_read_q) begin
                     spi_miso <= tx_q[DATA_W-1];
                     tx_q     <= {tx_q[DATA_W-2:0], 1'b0};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_rw_slave.sv
// Directed self-checking bench for spi_rw_slave with default widths.
module tb_spi_rw_slave;
   import spi_rw_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe;
   logic        wr_en, rd_en, abort;
   logic [23:0] wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data = '0;

   int n_tests = 0;
   int n_fail  = 0;

   spi_rw_slave dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sck    (spi_sck),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .abort      (abort)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_model(input logic [23:0] a);
      case (a)
         24'h000010: return 32'hCAFEF00D;
         24'h000011: return 32'h0BADBEEF;
         default:    return 32'h0;
      endcase
   endfunction

   // Register file model: data valid one clk after rd_en.
   always @(posedge clk) if (rd_en) rd_data <= rd_model(rd_addr);

   int          wr_cnt = 0, rd_cnt = 0, ab_cnt = 0, both_cnt = 0, oe_cnt = 0, miso_cnt = 0;
   logic [23:0] wr_addr_log [64];
   logic [31:0] wr_data_log [64];
   logic [23:0] rd_addr_log [64];

   always @(negedge clk) begin
      if (wr_en) begin
         wr_addr_log[wr_cnt[5:0]] <= wr_addr;
         wr_data_log[wr_cnt[5:0]] <= wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (rd_en) begin
         rd_addr_log[rd_cnt[5:0]] <= rd_addr;
         rd_cnt <= rd_cnt + 1;
      end
      if (abort) ab_cnt <= ab_cnt + 1;
      if (wr_en && abort) both_cnt <= both_cnt + 1;
      if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
      if (spi_miso) miso_cnt <= miso_cnt + 1;
   end

   task automatic cs_low();
      @(posedge clk); #1;
      spi_cs_n = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic cs_high();
      repeat (5) @(posedge clk);
      #1;
      spi_cs_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   // Master side: MOSI set during SCK low, MISO sampled just before each rise.
   task automatic spi_bits(input logic [63:0] val, input int n, output logic [63:0] got);
      got = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = val[i];
         repeat (5) @(posedge clk);
         #1;
         got = {got[62:0], spi_miso};
         spi_sck = 1'b1;
         repeat (5) @(posedge clk);
         #1;
         spi_sck = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", spi_miso); end
      n_tests++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
      n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
      n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
      n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got %b want 0", abort); end
      n_tests++; if (wr_addr !== 24'h0) begin n_fail++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
      n_tests++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
      n_tests++; if (rd_addr !== 24'h0) begin n_fail++; $display("FAIL reset_rd_addr got %h want 0", rd_addr); end
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_tests++; if (ab_cnt !== 0) begin n_fail++; $display("FAIL reset_release_abort got %0d want 0", ab_cnt); end
      n_tests++; if (dut.state_q !== StIdle) begin n_fail++; $display("FAIL reset_state got %0d want idle", dut.state_q); end
   endtask

   task automatic test_write();
      logic [63:0] g;
      int wb, rb, ab, ob;
      wb = wr_cnt; rb = rd_cnt; ab = ab_cnt; ob = oe_cnt;
      cs_low();
      spi_bits(64'hFF, 8, g);
      spi_bits(64'h123456, 24, g);
      spi_bits(64'hDEADBEEF, 32, g);
      cs_high();
      n_tests++; if (wr_cnt - wb !== 1) begin n_fail++; $display("FAIL write_count got %0d want 1", wr_cnt - wb); end
      n_tests++; if (wr_addr_log[wb[5:0]] !== 24'h123456) begin n_fail++; $display("FAIL write_addr got %h want 123456", wr_addr_log[wb[5:0]]); end
      n_tests++; if (wr_data_log[wb[5:0]] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_data got %h want deadbeef", wr_data_log[wb[5:0]]); end
      n_tests++; if (ab_cnt - ab !== 0) begin n_fail++; $display("FAIL write_abort got %0d want 0", ab_cnt - ab); end
      n_tests++; if (rd_cnt - rb !== 0 || oe_cnt - ob !== 0) begin n_fail++; $display("FAIL write_no_read got rd %0d oe %0d want 0 0", rd_cnt - rb, oe_cnt - ob); end
   endtask

   task automatic test_burst_wrap();
      logic [63:0] g;
      int wb;
      wb = wr_cnt;
      cs_low();
      spi_bits(64'hFF, 8, g);
      spi_bits(64'hFFFFFF, 24, g);
      spi_bits(64'h11111111, 32, g);
      spi_bits(64'h22222222, 32, g);
      cs_high();
      n_tests++; if (wr_cnt - wb !== 2) begin n_fail++; $display("FAIL burst_count got %0d want 2", wr_cnt - wb); end
      n_tests++; if (wr_addr_log[wb[5:0]] !== 24'hFFFFFF || wr_data_log[wb[5:0]] !== 32'h11111111) begin
         n_fail++; $display("FAIL burst_word0 got %h/%h want ffffff/11111111", wr_addr_log[wb[5:0]], wr_data_log[wb[5:0]]);
      end
      wb = wb + 1;
      n_tests++; if (wr_addr_log[wb[5:0]] !== 24'h000000 || wr_data_log[wb[5:0]] !== 32'h22222222) begin
         n_fail++; $display("FAIL burst_word1_wrap got %h/%h want 000000/22222222", wr_addr_log[wb[5:0]], wr_data_log[wb[5:0]]);
      end
      n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL wr_abort_overlap got %0d want 0", both_cnt); end
   endtask

   task automatic test_read();
      logic [63:0] g;
      int rb, wb, ab;
      rb = rd_cnt; wb = wr_cnt; ab = ab_cnt;
      cs_low();
      spi_bits(64'h0F, 8, g);
      n_tests++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_cmd got %b want 0", spi_miso_oe); end
      spi_bits(64'h000010, 24, g);
      n_tests++; if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL read_oe_data got %b want 1", spi_miso_oe); end
      spi_bits(64'h0, 64, g);
      n_tests++; if (g !== 64'hCAFEF00D_0BADBEEF) begin n_fail++; $display("FAIL read_miso got %h want cafef00d0badbeef", g); end
      cs_high();
      // Completing the second word prefetches a third address.
      n_tests++; if (rd_cnt - rb !== 3) begin n_fail++; $display("FAIL read_count got %0d want 3", rd_cnt - rb); end
      n_tests++; if (rd_addr_log[rb[5:0]] !== 24'h10) begin n_fail++; $display("FAIL read_addr0 got %h want 000010", rd_addr_log[rb[5:0]]); end
      rb = rb + 1;
      n_tests++; if (rd_addr_log[rb[5:0]] !== 24'h11) begin n_fail++; $display("FAIL read_addr1 got %h want 000011", rd_addr_log[rb[5:0]]); end
      n_tests++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin n_fail++; $display("FAIL read_release got oe %b miso %b want 0 0", spi_miso_oe, spi_miso); end
      n_tests++; if (wr_cnt - wb !== 0 || ab_cnt - ab !== 0) begin n_fail++; $display("FAIL read_side got wr %0d abort %0d want 0 0", wr_cnt - wb, ab_cnt - ab); end
   endtask

   task automatic test_unknown_cmd();
      logic [63:0] g;
      int wb, rb, ab, ob, mb;
      wb = wr_cnt; rb = rd_cnt; ab = ab_cnt; ob = oe_cnt; mb = miso_cnt;
      cs_low();
      spi_bits(64'h5A, 8, g);
      spi_bits(64'hA5C3_0F96_7E18_FF, 56, g);
      cs_high();
      n_tests++; if (wr_cnt - wb !== 0 || rd_cnt - rb !== 0) begin n_fail++; $display("FAIL unknown_strobes got wr %0d rd %0d want 0 0", wr_cnt - wb, rd_cnt - rb); end
      n_tests++; if (ab_cnt - ab !== 0) begin n_fail++; $display("FAIL unknown_abort got %0d want 0", ab_cnt - ab); end
      n_tests++; if (miso_cnt - mb !== 0 || oe_cnt - ob !== 0) begin n_fail++; $display("FAIL unknown_miso got miso %0d oe %0d want 0 0", miso_cnt - mb, oe_cnt - ob); end
   endtask

   task automatic test_abort();
      logic [63:0] g;
      int wb, ab;
      wb = wr_cnt; ab = ab_cnt;
      cs_low();
      spi_bits(64'hFF, 8, g);
      spi_bits(64'h000001, 24, g);
      spi_bits(64'hABC, 12, g);
      cs_high();
      n_tests++; if (wr_cnt - wb !== 0) begin n_fail++; $display("FAIL abort_no_write got %0d want 0", wr_cnt - wb); end
      n_tests++; if (ab_cnt - ab !== 1) begin n_fail++; $display("FAIL abort_pulse got %0d want 1", ab_cnt - ab); end
      n_tests++; if (dut.state_q !== StIdle) begin n_fail++; $display("FAIL abort_state got %0d want idle", dut.state_q); end
      ab = ab_cnt;
      cs_low();
      spi_bits(64'hFF, 8, g);
      spi_bits(64'h000002, 24, g);
      spi_bits(64'hA5A5A5A5, 32, g);
      cs_high();
      n_tests++; if (wr_cnt - wb !== 1 || wr_addr_log[wb[5:0]] !== 24'h2 || wr_data_log[wb[5:0]] !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL abort_recover got n %0d %h/%h want 1 000002/a5a5a5a5", wr_cnt - wb, wr_addr_log[wb[5:0]], wr_data_log[wb[5:0]]);
      end
      n_tests++; if (ab_cnt - ab !== 0) begin n_fail++; $display("FAIL abort_recover_abort got %0d want 0", ab_cnt - ab); end
   endtask

   task automatic test_cs_coincide();
      logic [63:0] g;
      logic [31:0] d;
      int wb, ab;
      wb = wr_cnt; ab = ab_cnt;
      d = 32'h2468ACF1;
      cs_low();
      spi_bits(64'hFF, 8, g);
      spi_bits(64'h000005, 24, g);
      spi_bits({33'h0, d[31:1]}, 31, g);
      spi_mosi = d[0];
      repeat (5) @(posedge clk);
      #1;
      spi_sck  = 1'b1;
      spi_cs_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      spi_sck = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      n_tests++; if (wr_cnt - wb !== 1 || wr_addr_log[wb[5:0]] !== 24'h5 || wr_data_log[wb[5:0]] !== d) begin
         n_fail++; $display("FAIL coincide_write got n %0d %h/%h want 1 000005/%h", wr_cnt - wb, wr_addr_log[wb[5:0]], wr_data_log[wb[5:0]], d);
      end
      n_tests++; if (ab_cnt - ab !== 0) begin n_fail++; $display("FAIL coincide_abort got %0d want 0", ab_cnt - ab); end
   endtask

   task automatic test_reset_mid_read();
      logic [63:0] g;
      int wb, rb, ab, ob, mb;
      cs_low();
      spi_bits(64'h0F, 8, g);
      spi_bits(64'h000010, 24, g);
      spi_bits(64'h0, 8, g);
      #3;
      rst = 1'b1;
      #1;
      n_tests++; if ({spi_miso, spi_miso_oe, wr_en, rd_en, abort} !== 5'b0) begin
         n_fail++; $display("FAIL midrst_outputs got %b want 00000", {spi_miso, spi_miso_oe, wr_en, rd_en, abort});
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      wb = wr_cnt; rb = rd_cnt; ab = ab_cnt; ob = oe_cnt; mb = miso_cnt;
      spi_bits(64'hFF00_0001_1234_5678, 40, g);
      n_tests++; if (wr_cnt - wb !== 0 || rd_cnt - rb !== 0 || ab_cnt - ab !== 0) begin
         n_fail++; $display("FAIL midrst_quiet got wr %0d rd %0d abort %0d want 0 0 0", wr_cnt - wb, rd_cnt - rb, ab_cnt - ab);
      end
      n_tests++; if (oe_cnt - ob !== 0 || miso_cnt - mb !== 0) begin
         n_fail++; $display("FAIL midrst_miso got oe %0d miso %0d want 0 0", oe_cnt - ob, miso_cnt - mb);
      end
      cs_high();
      n_tests++; if (ab_cnt - ab !== 0) begin n_fail++; $display("FAIL midrst_release_abort got %0d want 0", ab_cnt - ab); end
      wb = wr_cnt;
      cs_low();
      spi_bits(64'hFF, 8, g);
      spi_bits(64'h00ABCD, 24, g);
      spi_bits(64'h13579BDF, 32, g);
      cs_high();
      n_tests++; if (wr_cnt - wb !== 1 || wr_addr_log[wb[5:0]] !== 24'h00ABCD || wr_data_log[wb[5:0]] !== 32'h13579BDF) begin
         n_fail++; $display("FAIL midrst_recover got n %0d %h/%h want 1 00abcd/13579bdf", wr_cnt - wb, wr_addr_log[wb[5:0]], wr_data_log[wb[5:0]]);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_burst_wrap();
      test_read();
      test_unknown_cmd();
      test_abort();
      test_cs_coincide();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_rw_slave.md
# spi_rw_slave

Parametrised SPI mode-0 slave that bridges an external SPI master to the internal register bus. It is the successor to the write-only SCK-clocked receiver. It runs on the system clock with oversampled, synchronised SPI pins and adds a read command with MISO response, auto-incrementing bursts, parametrised widths and abort reporting. It sits between the board SPI pins and the register-file write/read ports.

## Interface
- ADDR_W, 24, address field width in bits (multiple of 8).
- DATA_W, 32, data word width in bits (multiple of 8).
- CMD_WRITE, 8'hFF, write command byte.
- CMD_READ, 8'h0F, read command byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable.
- wr_en  out  1  one-clk write strobe.
- wr_addr  out  ADDR_W  write address, valid with wr_en.
- wr_data  out  DATA_W  write data, valid with wr_en.
- rd_en  out  1  one-clk read request.
- rd_addr  out  ADDR_W  read address, valid with rd_en.
- rd_data  in  DATA_W  read data, valid exactly 1 clk after rd_en.
- abort  out  1  one-clk pulse on an incomplete-transaction CS release.

## Operation
- spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser. SCK edges are detected against a third flop.
- The block samples MOSI on the detected SCK rise and updates MISO on the detected SCK fall. All fields are MSB first.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE. A bit counter covers max(8, ADDR_W, DATA_W) bits.
- IDLE -> CMD: synchronised cs_n goes low.
- CMD -> ADDR: 8 bits received and the byte is CMD_WRITE or CMD_READ.
- CMD -> IGNORE: 8 bits received and the byte is any other value. IGNORE discards bits until CS goes high and raises no abort.
- ADDR -> DATA: ADDR_W bits received. The received value becomes the base address.
- Write, DATA state:
  - After each DATA_W bits, wr_en pulses with wr_addr = base + word_index and wr_data = the shifted word.
  - The state stays in DATA, so the burst continues.
- Read, DATA state:
  - On ADDR completion, rd_en pulses with rd_addr = base.
  - rd_data is captured 1 clk later into the TX shift register.
  - The first bit is driven on the next SCK fall.
  - After every DATA_W rises, the next rd_en is issued for base + word_index and its data is captured the same way.
- Address increment is +1 per word and wraps modulo 2^ADDR_W.
- spi_miso_oe is 1 only in DATA state of a read transaction; otherwise spi_miso is 0 and oe is 0.
- CS release (synchronised cs_n goes high) in any state:
  - The FSM goes to IDLE on the next clk and counters clear.
  - A partial word is discarded; already-completed words stand.
- abort pulses when CS rises in any of these cases:
  - in CMD with at least 1 bit received;
  - in ADDR;
  - in DATA with a nonzero partial bit count.

## Timing
- Reset values: spi_miso = 0, spi_miso_oe = 0, wr_en = 0, rd_en = 0, abort = 0, wr_addr = 0, wr_data = 0, rd_addr = 0; FSM in IDLE.
- Sampling latency: SCK pin rise to MOSI bit captured is 3 clk.
- wr_en asserts 1 clk after the capture of the last data bit and stays high for exactly 1 clk.
- rd_en asserts 1 clk after the capture of the last address bit (or last data bit of the previous read word).
- Supported SCK: high and low phases each at least 4 clk periods. This guarantees rd_data is loaded before the first MISO update.
- A CS rise coinciding with the last bit's capture: the word completes (wr_en fires) and abort does not fire.
- wr_en and abort never assert in the same clk.

## Structure
- Package spi_rw_pkg holds:
  - the state enum;
  - default CMD_WRITE and CMD_READ;
  - a function computing the counter width from ADDR_W and DATA_W.
- Sub-module spi_pin_sync: 2-flop synchroniser plus optional edge detect. It is instantiated for sck (with edges), cs_n and mosi.

## Test plan
- Write, default widths: CS low, send FF, 123456, DEADBEEF, CS high -> one wr_en with wr_addr = 24'h123456 and wr_data = 32'hDEADBEEF; abort = 0.
- Write burst with wrap: FF, FFFFFF, 11111111, 22222222 -> wr_en at addr FFFFFF with data 11111111, then at addr 000000 with data 22222222.
- Read: 0F, 000010; model returns 0xCAFEF00D for addr 10 and 0x0BADBEEF for addr 11; 64 SCKs clocked -> rd_en at 10 then 11; MISO shifts CAFEF00D then 0BADBEEF; oe high only during data.
- Unknown command: 5A followed by 56 SCKs -> no wr_en, no rd_en, no abort, MISO 0.
- Abort: FF, 000001, 12 data bits, CS high -> no wr_en, abort pulses once, FSM in IDLE. A following full write transaction succeeds.
- Reset mid-read: assert rst during DATA -> all outputs 0 immediately. After release with CS held low, no output activity until CS toggles high then low.
